accum_sequencer_4bit: RTL and testbench

ACCUM_SEQUENCER_4BIT -- requirements
Module: accum_sequencer_4bit

---
 rtl/accum_sequencer_4bit_pkg.sv | 27 ++
 rtl/adder_subtractor_4bit.sv | 32 +++
 rtl/accum_sequencer_4bit.sv | 126 ++++++++++++
 tb/tb_accum_sequencer_4bit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_sequencer_4bit_pkg.sv
// ============================================================================
// Module : accum_sequencer_4bit_pkg
// Brief  : Shared op and FSM state encodings for the 4-bit accumulator sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package accum_sequencer_4bit_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

`default_nettype wire

// File: rtl/adder_subtractor_4bit.sv
// ============================================================================
// Module : adder_subtractor_4bit
// Brief  : 4-bit ripple-carry adder/subtractor; i_sel=1 computes i_a - i_b.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_subtractor_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_sel,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [3:0] w_bx;
    logic [4:0] w_c;

    // Subtraction is A + ~B + 1, so sel doubles as the carry-in.
    assign w_bx   = i_b ^ {4{i_sel}};
    assign w_c[0] = i_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_ripple
        assign o_sum[gi]  = i_a[gi] ^ w_bx[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (i_a[gi] & w_bx[gi]) | (w_c[gi] & (i_a[gi] ^ w_bx[gi]));
    end

    assign o_cout = w_c[4];

endmodule

`default_nettype wire

// File: rtl/accum_sequencer_4bit.sv
// ============================================================================
// Module : accum_sequencer_4bit
// Brief  : Handshaked accumulator executing LOAD/ADD/SUB/CLR, ADD/SUB repeated.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_sequencer_4bit
    import accum_sequencer_4bit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] operand,
    input  logic [1:0]        rep,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic              ovf,
    output logic              zero,
    output logic              out_valid,
    input  logic              out_ready
);

    state_e              r_state;
    state_e              w_state_nxt;
    op_e                 r_op;
    logic [DATA_W-1:0]   r_operand;
    logic [1:0]          r_remaining;
    logic [DATA_W-1:0]   r_acc;
    logic                r_carry;
    logic                r_ovf;

    logic [DATA_W-1:0]   w_sum;
    logic                w_cout;
    logic                w_sel;
    logic                w_bx_msb;
    logic                w_step_ovf;
    logic                w_arith;
    logic                w_in_ready;
    logic                w_out_valid;

    assign w_sel   = (r_op == OP_SUB);
    assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);

    adder_subtractor_4bit u_addsub (
        .i_a    (r_acc),
        .i_b    (r_operand),
        .i_sel  (w_sel),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Signed overflow: operands (after conditional inversion) agree in sign but the result does not.
    assign w_bx_msb   = r_operand[DATA_W-1] ^ w_sel;
    assign w_step_ovf = (r_acc[DATA_W-1] == w_bx_msb) && (w_sum[DATA_W-1] != r_acc[DATA_W-1]);

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (!w_arith || (r_remaining == 2'd0)) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_LOAD;
            r_operand   <= '0;
            r_remaining <= 2'd0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    // Carry deliberately holds until the first step of the new command.
                    if (in_valid) begin
                        r_op        <= op_e'(op);
                        r_operand   <= operand;
                        r_remaining <= rep;
                        r_ovf       <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    if (w_arith) begin
                        r_acc   <= w_sum;
                        r_carry <= w_cout;
                        r_ovf   <= r_ovf | w_step_ovf;
                        if (r_remaining != 2'd0) r_remaining <= r_remaining - 2'd1;
                    end else begin
                        r_acc   <= (r_op == OP_LOAD) ? r_operand : '0;
                        r_carry <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign acc       = r_acc;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign zero      = (r_acc == '0);

endmodule

`default_nettype wire

// File: tb/tb_accum_sequencer_4bit.sv
// ============================================================================
// Module : tb_accum_sequencer_4bit
// Brief  : Directed bench with an arithmetic reference model of the sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accum_sequencer_4bit;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [3:0] operand;
    logic [1:0] rep;
    logic [3:0] acc;
    logic       carry;
    logic       ovf;
    logic       zero;
    logic       out_valid;
    logic       out_ready;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Reference model state
    int m_acc   = 0;
    bit m_carry = 0;
    bit m_ovf   = 0;
    int m_left  = 0;
    bit m_done  = 0;
    int m_op    = 0;
    int m_opd   = 0;

    accum_sequencer_4bit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand   (operand),
        .rep       (rep),
        .acc       (acc),
        .carry     (carry),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sval(input int v);
        return (v > 7) ? v - 16 : v;
    endfunction

    function automatic bit oor(input int v);
        return (v > 7) || (v < -8);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: acceptance -> N steps of plain modular/signed arithmetic -> done until acked
    always @(posedge clk) begin
        if (reset) begin
            m_acc <= 0; m_carry <= 0; m_ovf <= 0; m_left <= 0; m_done <= 0;
            m_op <= 0; m_opd <= 0;
        end else if (m_left > 0) begin
            if (m_op == 1) begin
                m_acc   <= (m_acc + m_opd) % 16;
                m_carry <= (m_acc + m_opd) > 15;
                m_ovf   <= m_ovf || oor(sval(m_acc) + sval(m_opd));
            end else if (m_op == 2) begin
                m_acc   <= (m_acc - m_opd + 16) % 16;
                m_carry <= (m_acc >= m_opd);
                m_ovf   <= m_ovf || oor(sval(m_acc) - sval(m_opd));
            end else begin
                m_acc   <= (m_op == 0) ? m_opd : 0;
                m_carry <= 0;
                m_ovf   <= 0;
            end
            m_left <= m_left - 1;
            if (m_left == 1) m_done <= 1;
        end else if (m_done) begin
            if (out_ready) m_done <= 0;
        end else if (in_valid) begin
            m_op   <= int'(op);
            m_opd  <= int'(operand);
            m_ovf  <= 0;
            m_left <= (op == 2'd1 || op == 2'd2) ? int'(rep) + 1 : 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_acc",       int'(acc),       m_acc);
            chk("cmp_carry",     int'(carry),     int'(m_carry));
            chk("cmp_ovf",       int'(ovf),       int'(m_ovf));
            chk("cmp_zero",      int'(zero),      int'(m_acc == 0));
            chk("cmp_out_valid", int'(out_valid), int'(m_done));
            chk("cmp_in_ready",  int'(in_ready),  int'(m_left == 0 && !m_done));
        end
    end

    // Presents one command at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input logic [1:0] o, input logic [3:0] v, input logic [1:0] r);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("issue_ready_timeout", 0, 1);
        in_valid = 1'b1; op = o; operand = v; rep = r;
        @(negedge clk);
        in_valid = 1'b0;
        op = 2'($urandom); operand = 4'($urandom); rep = 2'($urandom);
    endtask

    // Latency counted in cycles from acceptance to out_valid.
    task automatic wait_done(input int steps);
        int k;
        k = 1;
        while (!out_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, steps + 1);
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ack_idle_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; op = 2'd0; operand = 4'd0; rep = 2'd0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_zero",      int'(zero),      1);
        chk("rst_acc",       int'(acc),       0);

        // Scenario 1: 5 + 3 overflows signed
        issue(2'd0, 4'd5, 2'd0); wait_done(1); ack();
        issue(2'd1, 4'd3, 2'd0); wait_done(1);
        chk("s1_acc", int'(acc), 8);
        chk("s1_carry", int'(carry), 0);
        chk("s1_ovf", int'(ovf), 1);
        chk("s1_zero", int'(zero), 0);
        ack();

        // Scenario 2: borrow, then wrap to zero
        issue(2'd0, 4'd2, 2'd0); wait_done(1); ack();
        issue(2'd2, 4'd3, 2'd0); wait_done(1);
        chk("s2a_acc", int'(acc), 15);
        chk("s2a_carry", int'(carry), 0);
        chk("s2a_ovf", int'(ovf), 0);
        ack();
        issue(2'd2, 4'd15, 2'd0); wait_done(1);
        chk("s2b_acc", int'(acc), 0);
        chk("s2b_zero", int'(zero), 1);
        chk("s2b_carry", int'(carry), 1);
        ack();

        // Scenario 3: four repeated adds
        issue(2'd0, 4'd1, 2'd0); wait_done(1); ack();
        issue(2'd1, 4'd4, 2'd3); wait_done(4);
        chk("s3_acc", int'(acc), 1);
        chk("s3_carry", int'(carry), 1);
        chk("s3_ovf", int'(ovf), 1);

        // Scenario 4: stall in DONE while the input side churns
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            op = 2'($urandom);
            operand = 4'($urandom);
            @(negedge clk);
            chk("s4_hold_acc", int'(acc), 1);
            chk("s4_hold_valid", int'(out_valid), 1);
            chk("s4_hold_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        ack();

        // Scenario 5: reset in the second EXEC cycle
        issue(2'd0, 4'd7, 2'd0); wait_done(1); ack();
        issue(2'd1, 4'd2, 2'd3);
        @(negedge clk);
        chk("s5_mid_acc", int'(acc), 9);
        reset = 1'b1;
        @(negedge clk);
        chk("s5_rst_out_valid", int'(out_valid), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("s5_in_ready", int'(in_ready), 1);
        chk("s5_acc", int'(acc), 0);
        chk("s5_zero", int'(zero), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("s5_no_out_valid", int'(out_valid), 0);
        end

        // Scenario 6: reach acc=9 with carry set, then CLR
        issue(2'd0, 4'd12, 2'd0); wait_done(1); ack();
        issue(2'd1, 4'd13, 2'd0); wait_done(1);
        chk("s6_pre_acc", int'(acc), 9);
        chk("s6_pre_carry", int'(carry), 1);
        ack();
        issue(2'd3, 4'd6, 2'd2); wait_done(1);
        chk("s6_acc", int'(acc), 0);
        chk("s6_zero", int'(zero), 1);
        chk("s6_carry", int'(carry), 0);
        chk("s6_ovf", int'(ovf), 0);
        ack();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
